// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: function codes, frame header,
// controller states and status-byte layout.
package alu_pkg;

  localparam logic [3:0] FUN_ADD    = 4'b0000;
  localparam logic [3:0] FUN_SUB    = 4'b0001;
  localparam logic [3:0] FUN_MUL    = 4'b0010;
  localparam logic [3:0] FUN_DIV    = 4'b0011;
  localparam logic [3:0] FUN_AND    = 4'b0100;
  localparam logic [3:0] FUN_OR     = 4'b0101;
  localparam logic [3:0] FUN_NAND   = 4'b0110;
  localparam logic [3:0] FUN_NOR    = 4'b0111;
  localparam logic [3:0] FUN_XOR    = 4'b1000;
  localparam logic [3:0] FUN_XNOR   = 4'b1001;
  localparam logic [3:0] FUN_CMP_EQ = 4'b1010;
  localparam logic [3:0] FUN_CMP_GT = 4'b1011;
  localparam logic [3:0] FUN_CMP_LT = 4'b1100;
  localparam logic [3:0] FUN_SHR    = 4'b1101;
  localparam logic [3:0] FUN_SHL    = 4'b1110;

  localparam logic [3:0] SYNC_HDR = 4'hA;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_GET_A    = 3'd1;
  localparam state_t S_GET_B    = 3'd2;
  localparam state_t S_EXEC     = 3'd3;
  localparam state_t S_CAPT     = 3'd4;
  localparam state_t S_SEND_RES = 3'd5;
  localparam state_t S_SEND_STS = 3'd6;

  localparam int DIV0_BIT = 7;

endpackage

// File: rtl/alu_frame_rx.sv
// Receive side of the command link: header check, little-endian operand assembly
// and inter-byte timeout. Emits single-cycle events that steer the main FSM.
module alu_frame_rx
  import alu_pkg::*;
#(
  parameter int         WIDTH   = 16,
  parameter int         WFUN    = 4,
  parameter logic [3:0] SYNC    = SYNC_HDR,
  parameter int         TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  state_t           i_state,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WFUN-1:0]  o_fun,
  output logic             o_hdr_ok,
  output logic             o_hdr_bad,
  output logic             o_a_done,
  output logic             o_frame_done,
  output logic             o_timeout
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          w_in_get;
  logic          w_acc;
  logic          w_last;
  logic          w_sync;

  assign w_in_get     = (i_state == S_GET_A) || (i_state == S_GET_B);
  assign o_rx_ready   = !i_rst && ((i_state == S_IDLE) || w_in_get);
  assign w_acc        = i_rx_valid && o_rx_ready;
  assign w_last       = (r_cnt == CW'(NBYTES - 1));
  assign w_sync       = (i_rx_data[7:4] == SYNC);
  assign o_hdr_ok     = w_acc && (i_state == S_IDLE) && w_sync;
  assign o_hdr_bad    = w_acc && (i_state == S_IDLE) && !w_sync;
  assign o_a_done     = w_acc && (i_state == S_GET_A) && w_last;
  assign o_frame_done = w_acc && (i_state == S_GET_B) && w_last;
  // Fires at the end of the TIMEOUT-th consecutive cycle without a byte.
  assign o_timeout    = w_in_get && !w_acc && (r_to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_to_cnt <= '0;
      o_a      <= '0;
      o_b      <= '0;
      o_fun    <= '0;
    end else begin
      if (o_hdr_ok) begin
        o_fun <= i_rx_data[WFUN-1:0];
        r_cnt <= '0;
      end
      if (w_acc && w_in_get) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (r_cnt == CW'(i)) begin
            if (i_state == S_GET_A) o_a[8*i +: 8] <= i_rx_data;
            else                    o_b[8*i +: 8] <= i_rx_data;
          end
        end
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (!w_in_get || w_acc) r_to_cnt <= '0;
      else                    r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command front end for the registered ALU: takes a framed command, drives the ALU,
// waits out its register stage, then returns result bytes plus a status byte.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int         WIDTH   = 16,
  parameter int         WFUN    = 4,
  parameter int         WFLAG   = 4,
  parameter logic [3:0] SYNC    = SYNC_HDR,
  parameter int         TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_VALID,
  output logic             RX_READY,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WFUN-1:0]  ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic [WFLAG-1:0] Flags_out,
  output logic             BUSY,
  output logic             FRM_ERR,
  output state_t           o_dbg_state
);

  // Both links: a byte moves on a clock edge where VALID && READY are both high;
  // the sender holds DATA/VALID stable until that happens.
  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_result;
  logic [7:0]       r_status;
  logic [CW-1:0]    r_tx_cnt;
  logic             r_frm_err;
  logic             w_hdr_ok, w_hdr_bad, w_a_done, w_frame_done, w_timeout;
  logic             w_tx_acc, w_tx_last, w_div0;
  logic [7:0]       w_status, w_res_byte;

  alu_frame_rx #(
    .WIDTH(WIDTH), .WFUN(WFUN), .SYNC(SYNC), .TIMEOUT(TIMEOUT)
  ) u_rx (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_state     (r_state),
    .i_rx_data   (RX_DATA),
    .i_rx_valid  (RX_VALID),
    .o_rx_ready  (RX_READY),
    .o_a         (A),
    .o_b         (B),
    .o_fun       (ALU_FUN),
    .o_hdr_ok    (w_hdr_ok),
    .o_hdr_bad   (w_hdr_bad),
    .o_a_done    (w_a_done),
    .o_frame_done(w_frame_done),
    .o_timeout   (w_timeout)
  );

  assign TX_VALID    = (r_state == S_SEND_RES) || (r_state == S_SEND_STS);
  assign BUSY        = (r_state != S_IDLE);
  assign FRM_ERR     = r_frm_err;
  assign o_dbg_state = r_state;
  assign w_tx_acc    = TX_VALID && TX_READY;
  assign w_tx_last   = (r_tx_cnt == CW'(NBYTES - 1));

  always_comb begin
    // Divide by zero overrides whatever the ALU produced.
    w_div0             = (ALU_FUN == WFUN'(FUN_DIV)) && (B == '0);
    w_status           = '0;
    w_status[DIV0_BIT] = w_div0;
    w_status[WFLAG-1:0] = Flags_out;
    w_res_byte         = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_tx_cnt == CW'(i)) w_res_byte = r_result[8*i +: 8];
    end
    TX_DATA = '0;
    if (r_state == S_SEND_RES)      TX_DATA = w_res_byte;
    else if (r_state == S_SEND_STS) TX_DATA = r_status;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_hdr_ok) w_next = S_GET_A;
      S_GET_A:    if (w_timeout) w_next = S_IDLE;
                  else if (w_a_done) w_next = S_GET_B;
      S_GET_B:    if (w_timeout) w_next = S_IDLE;
                  else if (w_frame_done) w_next = S_EXEC;
      S_EXEC:     w_next = S_CAPT;
      S_CAPT:     w_next = S_SEND_RES;
      S_SEND_RES: if (w_tx_acc && w_tx_last) w_next = S_SEND_STS;
      S_SEND_STS: if (w_tx_acc) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_status  <= '0;
      r_tx_cnt  <= '0;
      r_frm_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_frm_err <= w_hdr_bad || w_timeout;
      if (r_state == S_CAPT) begin
        r_result <= w_div0 ? '1 : ALU_OUT;
        r_status <= w_status;
        r_tx_cnt <= '0;
      end else if (r_state == S_SEND_RES && w_tx_acc) begin
        r_tx_cnt <= w_tx_last ? '0 : r_tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: a registered ALU model closes the loop, expected TX bytes
// are queued when a frame is driven and compared as the DUT sends them.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int WFUN  = 4;
  localparam int WFLAG = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [7:0]       RX_DATA;
  logic             RX_VALID;
  logic             RX_READY;
  logic [7:0]       TX_DATA;
  logic             TX_VALID;
  logic             TX_READY;
  logic [WIDTH-1:0] A, B;
  logic [WFUN-1:0]  ALU_FUN;
  logic [WIDTH-1:0] ALU_OUT;
  logic [WFLAG-1:0] Flags_out;
  logic             BUSY;
  logic             FRM_ERR;
  state_t           o_dbg_state;

  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int tx_count = 0;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .A(A), .B(B),
    .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .Flags_out(Flags_out), .BUSY(BUSY),
    .FRM_ERR(FRM_ERR), .o_dbg_state(o_dbg_state)
  );

  // ---- clock / reset ----
  always #5 CLK = ~CLK;

  // ---- registered ALU model: {flags, result}; flag bit0 arith, 1 logic, 2 compare, 3 shift
  function automatic logic [WFLAG+WIDTH-1:0] alu_ref(input logic [3:0] f,
                                                    input logic [WIDTH-1:0] a, b);
    logic [WIDTH-1:0] r;
    logic [WFLAG-1:0] fl;
    r = '0; fl = '0;
    case (f)
      FUN_ADD:    begin r = a + b;  fl = 4'b0001; end
      FUN_SUB:    begin r = a - b;  fl = 4'b0001; end
      FUN_MUL:    begin r = a * b;  fl = 4'b0001; end
      FUN_DIV:    begin r = (b == 0) ? '0 : a / b; fl = 4'b0001; end
      FUN_AND:    begin r = a & b;  fl = 4'b0010; end
      FUN_OR:     begin r = a | b;  fl = 4'b0010; end
      FUN_NAND:   begin r = ~(a & b); fl = 4'b0010; end
      FUN_NOR:    begin r = ~(a | b); fl = 4'b0010; end
      FUN_XOR:    begin r = a ^ b;  fl = 4'b0010; end
      FUN_XNOR:   begin r = ~(a ^ b); fl = 4'b0010; end
      FUN_CMP_EQ: begin r = (a == b) ? 1 : 0; fl = 4'b0100; end
      FUN_CMP_GT: begin r = (a > b) ? 2 : 0;  fl = 4'b0100; end
      FUN_CMP_LT: begin r = (a < b) ? 3 : 0;  fl = 4'b0100; end
      FUN_SHR:    begin r = a >> 1; fl = 4'b1000; end
      FUN_SHL:    begin r = a << 1; fl = 4'b1000; end
      default:    begin r = '0; fl = '0; end
    endcase
    return {fl, r};
  endfunction

  always @(posedge CLK) {Flags_out, ALU_OUT} <= alu_ref(ALU_FUN, A, B);

  // ---- checking ----
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---- scoreboard: compare each TX transfer against the queue head ----
  always @(negedge CLK) begin
    if (!RST && TX_VALID && TX_READY) begin
      tx_count++;
      if (exp_q.size() == 0) check_eq("tx_spurious", {24'h0, TX_DATA}, 32'h100);
      else                   check_eq("tx_byte", {24'h0, TX_DATA}, {24'h0, exp_q.pop_front()});
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    forever begin
      @(negedge CLK);
      if (RX_READY) begin tick(); break; end
      t++;
      if (t > 100) begin check_eq("rx_ready_wait", RX_READY, 1'b1); tick(); break; end
    end
    RX_VALID = 1'b0;
  endtask

  task automatic push_expected(input logic [3:0] f, input logic [WIDTH-1:0] a, b);
    logic [WFLAG+WIDTH-1:0] v;
    logic [WIDTH-1:0] r;
    logic [7:0] sts;
    logic dz;
    v   = alu_ref(f, a, b);
    dz  = (f == FUN_DIV) && (b == 0);
    r   = dz ? '1 : v[WIDTH-1:0];
    sts = {dz, 3'b000, v[WFLAG+WIDTH-1:WIDTH]};
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(sts);
  endtask

  task automatic send_frame(input logic [3:0] f, input logic [WIDTH-1:0] a, b, input bit push);
    if (push) push_expected(f, a, b);
    send_byte({SYNC_HDR, f});
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
  endtask

  task automatic wait_tx_valid(output int n);
    n = 0;
    forever begin
      @(negedge CLK);
      n++;
      if (TX_VALID) break;
      if (n > 20) begin check_eq("tx_valid_wait", TX_VALID, 1'b1); break; end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge CLK);
      if (exp_q.size() == 0 && o_dbg_state == S_IDLE) break;
      t++;
      if (t > 100) begin check_eq("drain_wait", exp_q.size(), 0); break; end
    end
    tick();
  endtask

  // ---- main sequence ----
  initial begin
    int n;
    int tx_before;
    logic [3:0] f;
    logic [WIDTH-1:0] ra, rb;

    RST = 1'b1; RX_DATA = '0; RX_VALID = 1'b0; TX_READY = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    check_eq("rst_tx_valid", TX_VALID, 0);
    check_eq("rst_frm_err", FRM_ERR, 0);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_rx_ready", RX_READY, 0);
    check_eq("rst_a", A, 0);
    check_eq("rst_b", B, 0);
    check_eq("rst_fun", ALU_FUN, 0);
    check_eq("rst_state", o_dbg_state, S_IDLE);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check_eq("idle_rx_ready", RX_READY, 1);
    tick();

    // ADD with latency check: TX_VALID on the third cycle after the last byte
    send_frame(FUN_ADD, 16'h1234, 16'h0101, 1'b1);
    wait_tx_valid(n);
    check_eq("add_latency", n, 3);
    check_eq("add_a", A, 16'h1234);
    check_eq("add_b", B, 16'h0101);
    wait_idle();

    send_frame(FUN_SUB, 16'h0005, 16'h0007, 1'b1);
    wait_idle();

    send_frame(FUN_DIV, 16'h0010, 16'h0000, 1'b1);
    wait_idle();

    // bad sync byte
    tx_before = tx_count;
    send_byte(8'h53);
    @(negedge CLK);
    check_eq("badsync_frm_err", FRM_ERR, 1);
    check_eq("badsync_busy", BUSY, 0);
    check_eq("badsync_rx_ready", RX_READY, 1);
    @(negedge CLK);
    check_eq("badsync_frm_err_clr", FRM_ERR, 0);
    check_eq("badsync_no_tx", tx_count, tx_before);
    tick();
    send_frame(FUN_ADD, 16'h1234, 16'h0101, 1'b1);
    wait_idle();

    // inter-byte timeout
    send_byte({SYNC_HDR, FUN_ADD});
    send_byte(8'h34);
    n = 0;
    forever begin
      @(negedge CLK);
      if (FRM_ERR) break;
      n++;
      if (n > 400) break;
    end
    check_eq("timeout_cycles", n, 255);
    check_eq("timeout_state", o_dbg_state, S_IDLE);
    check_eq("timeout_busy", BUSY, 0);
    @(negedge CLK);
    check_eq("timeout_frm_err_clr", FRM_ERR, 0);
    tick();
    send_frame(FUN_MUL, 16'h0123, 16'h0011, 1'b1);
    wait_idle();

    // TX backpressure, with a header offered that must not be taken
    TX_READY = 1'b0;
    send_frame(FUN_ADD, 16'h1234, 16'h0101, 1'b1);
    wait_tx_valid(n);
    tick();
    RX_DATA = 8'hA1; RX_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_eq("bp_tx_data", TX_DATA, 8'h35);
      check_eq("bp_tx_valid", TX_VALID, 1);
      check_eq("bp_rx_ready", RX_READY, 0);
    end
    check_eq("bp_state", o_dbg_state, S_SEND_RES);
    tick();
    RX_VALID = 1'b0; TX_READY = 1'b1;
    wait_idle();

    // random frames, divide-by-zero made likely
    for (int k = 0; k < 8; k++) begin
      f  = 4'($urandom_range(0, 14));
      ra = 16'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
      send_frame(f, ra, rb, 1'b1);
      wait_idle();
    end

    // reset during SEND_RES drops the response
    TX_READY  = 1'b0;
    tx_before = tx_count;
    send_frame(FUN_ADD, 16'h1234, 16'h0101, 1'b0);
    wait_tx_valid(n);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    check_eq("rstmid_rx_ready", RX_READY, 0);
    @(negedge CLK);
    check_eq("rstmid_tx_valid", TX_VALID, 0);
    check_eq("rstmid_busy", BUSY, 0);
    check_eq("rstmid_frm_err", FRM_ERR, 0);
    check_eq("rstmid_a", A, 0);
    check_eq("rstmid_b", B, 0);
    check_eq("rstmid_fun", ALU_FUN, 0);
    check_eq("rstmid_state", o_dbg_state, S_IDLE);
    tick();
    RST = 1'b0; TX_READY = 1'b1;
    repeat (3) tick();
    check_eq("rstmid_no_tx", tx_count, tx_before);
    send_frame(FUN_XOR, 16'hF0F0, 16'h1234, 1'b1);
    wait_idle();

    check_eq("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command front end that sits directly upstream of the registered 16-bit ALU and also collects its result.
- Receives byte-serial command frames on a valid/ready link: a header carrying sync + ALU_FUN, then operand A and operand B, each little-endian.
- Drives A/B/ALU_FUN into the ALU and waits out its one-cycle register latency.
- Captures ALU_OUT and Flags_out, then returns result bytes plus a status byte on a byte-serial valid/ready link.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 8; NBYTES = WIDTH/8.
- WFUN, 4, ALU function code width.
- WFLAG, 4, ALU flag vector width (≤ 7).
- SYNC, 4'hA, required value of header bits [7:4].
- TIMEOUT, 255, maximum idle cycles between bytes inside a frame.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  8  incoming frame byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  block accepts a byte; a transfer occurs when RX_VALID && RX_READY.
- TX_DATA  out  8  response byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  sink accepts a byte.
- A  out  WIDTH  ALU operand A.
- B  out  WIDTH  ALU operand B.
- ALU_FUN  out  WFUN  ALU function select.
- ALU_OUT  in  WIDTH  registered ALU result.
- Flags_out  in  WFLAG  registered ALU flags.
- BUSY  out  1  high in every state except IDLE.
- FRM_ERR  out  1  one-cycle pulse on a dropped frame.

Behaviour:
- Reset:
  - RST sampled high → state IDLE; A, B, ALU_FUN, result register, status register, byte counter and timeout counter all 0.
  - TX_VALID = 0, FRM_ERR = 0, BUSY = 0; RX_READY = 0 while RST is high.
  - Reset mid-frame or mid-send discards everything, with no partial TX.
- States: IDLE, GET_A, GET_B, EXEC, CAPT, SEND_RES, SEND_STS.
- RX_READY is a combinational decode of state: 1 in IDLE/GET_A/GET_B, 0 elsewhere. TX_VALID is 1 only in SEND_RES/SEND_STS.
- IDLE, on an accepted byte:
  - If byte[7:4] == SYNC: ALU_FUN ← byte[3:0], byte counter ← 0, go to GET_A.
  - Otherwise: FRM_ERR pulses in the next cycle, stay in IDLE.
- GET_A / GET_B:
  - Byte i is written to bits [8i+7:8i] of A (or B).
  - Counter wraps at NBYTES-1: GET_A → GET_B; GET_B → EXEC.
- EXEC (1 cycle): A/B/ALU_FUN are stable and the ALU registers its output at the end of this cycle.
- CAPT (1 cycle):
  - Normal case: result ← ALU_OUT; status ← {div0, 0…, Flags_out}.
  - div0 = (ALU_FUN == 4'b0011 && B == 0). If div0, result ← all ones and the ALU_OUT value is ignored.
- Latency: last B byte accepted at edge k → EXEC in cycle k+1 → CAPT in cycle k+2 → TX_VALID = 1 from the cycle after edge k+2.
- SEND_RES:
  - TX_DATA = result byte[cnt], least-significant first.
  - Advance only on TX_VALID && TX_READY; after NBYTES bytes go to SEND_STS.
- SEND_STS: TX_DATA = status byte (bit7 = div0, bits [WFLAG-1:0] = flags); on acceptance go to IDLE.
- TX backpressure: TX_DATA and TX_VALID are held stable while TX_READY = 0; no RX bytes are accepted during send.
- A, B and ALU_FUN keep their last values after a frame; they are only overwritten by the next frame.
- Timeout:
  - In GET_A/GET_B the timeout counter increments each cycle with no accepted byte and clears on an accepted byte.
  - Reaching TIMEOUT → FRM_ERR one-cycle pulse, state IDLE, partial operands discarded (registers may retain partial values).
- A header accepted in the same cycle as a timeout cannot occur; IDLE has no timeout.
- BUSY = (state != IDLE).

Decomposition:
- Shared package alu_pkg holds:
  - the ALU_FUN encodings (ADD 0000 … SHL 1110; DIV = 0011);
  - SYNC_HDR;
  - the state enum;
  - the status-byte bit positions (DIV0_BIT = 7).
- One natural sub-module, alu_frame_rx: header check, byte assembly and timeout counter; it presents A/B/FUN with a one-cycle frame_done pulse to the main FSM.

Test Plan:
- ADD: RX A0,34,12,01,01 → A=0x1234, B=0x0101; TX 35,13,01; TX_VALID rises 3 cycles after the last RX byte.
- SUB wrap: RX A1,05,00,07,00 → TX FE,FF,01.
- Divide by zero: RX A3,10,00,00,00 → TX FF,FF,81 (div0 bit set, arithmetic flag bit 0 set).
- Bad sync: RX 53 → FRM_ERR pulses once, no TX, RX_READY stays 1, BUSY stays 0; a following valid ADD frame still completes correctly.
- Timeout: RX A0,34 then RX_VALID = 0 for 255 cycles → FRM_ERR pulses exactly at the 255th idle cycle, state IDLE; the next full frame completes correctly.
- Backpressure and reset:
  - TX_READY low for 10 cycles during SEND_RES → TX_DATA held at 0x35, RX_READY = 0.
  - Assert RST during SEND_RES → TX_VALID = 0 the next cycle; all outputs at their reset values.
